alu_imm_exec_unit: RTL and testbench

//  Registered, handshaked execution unit for RV OP-IMM instructions (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI).

---
 rtl/alu_imm_exec_unit_pkg.sv | 32 +++
 rtl/alu_imm_exec_unit_if.sv | 30 +++
 rtl/alu_imm_exec_unit_shifter.sv | 71 +++++++
 rtl/alu_imm_exec_unit.sv | 139 +++++++++++++
 tb/tb_alu_imm_exec_unit.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_imm_exec_unit_pkg.sv
// Shared types and OP-IMM funct3 encodings for the OP-IMM execution unit.
// Also defines the FSM state and shift-kind enums used by the top and its shifter.
package alu_imm_exec_unit_pkg;

  localparam logic [2:0] ALU_IMM_FUNCT3_ADDI  = 3'b000;
  localparam logic [2:0] ALU_IMM_FUNCT3_SLLI  = 3'b001;
  localparam logic [2:0] ALU_IMM_FUNCT3_SLTI  = 3'b010;
  localparam logic [2:0] ALU_IMM_FUNCT3_SLTIU = 3'b011;
  localparam logic [2:0] ALU_IMM_FUNCT3_XORI  = 3'b100;
  localparam logic [2:0] ALU_IMM_FUNCT3_SRXI  = 3'b101;
  localparam logic [2:0] ALU_IMM_FUNCT3_ORI   = 3'b110;
  localparam logic [2:0] ALU_IMM_FUNCT3_ANDI  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_imm_state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } alu_imm_shift_op_e;

  // imm12[10] distinguishes SRAI from SRLI; SLLI ignores it.
  function automatic alu_imm_shift_op_e shift_op(input logic [2:0] funct3, input logic imm_b10);
    if (funct3 == ALU_IMM_FUNCT3_SLLI) return SH_SLL;
    return imm_b10 ? SH_SRA : SH_SRL;
  endfunction

endpackage

// File: rtl/alu_imm_exec_unit_if.sv
// Request/write-back bundle of the OP-IMM execution unit.
// The slave modport is the unit's view; master is the decode/write-back side.
interface alu_imm_exec_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_vld;
  logic              in_rdy;
  logic [2:0]        in_funct3;
  logic [11:0]       in_imm12;
  logic [XLEN-1:0]   in_rs1_data;
  logic [REG_AW-1:0] in_rd;

  logic              wb_vld;
  logic              wb_rdy;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              wb_wen;
  logic              wb_illegal;

  modport slave (
    input  in_vld, in_funct3, in_imm12, in_rs1_data, in_rd, wb_rdy,
    output in_rdy, wb_vld, wb_rd, wb_data, wb_wen, wb_illegal
  );

  modport master (
    output in_vld, in_funct3, in_imm12, in_rs1_data, in_rd, wb_rdy,
    input  in_rdy, wb_vld, wb_rd, wb_data, wb_wen, wb_illegal
  );
endinterface

// File: rtl/alu_imm_exec_unit_shifter.sv
// Shift datapath: single-cycle barrel by default, or SHIFT_STEP bits per cycle
// with a residual-count register when ALU_IMM_SERIAL_SHIFT_EN is defined.
module alu_imm_shifter
  import alu_imm_exec_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  localparam int SAW       = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              advance_i,
  input  alu_imm_shift_op_e op_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic [SAW-1:0]    shamt_i,
  output logic [XLEN-1:0]   comb_o,
  output logic [XLEN-1:0]   step_o,
  output logic              last_o
);

  function automatic logic [XLEN-1:0] shift_by(input alu_imm_shift_op_e op,
                                               input logic [XLEN-1:0] v,
                                               input logic [SAW-1:0] amt);
    case (op)
      SH_SLL:  return v << amt;
      SH_SRA:  return $unsigned($signed(v) >>> amt);
      default: return v >> amt;
    endcase
  endfunction

`ifdef ALU_IMM_SERIAL_SHIFT_EN
  localparam int SW = $clog2(SHIFT_STEP + 1);

  logic [XLEN-1:0]   val_q;
  logic [SAW-1:0]    cnt_q;
  alu_imm_shift_op_e op_q;
  logic [SW-1:0]     step_amt;

  // The final step consumes whatever residual is left, which is at most SHIFT_STEP.
  assign last_o   = cnt_q <= SAW'(SHIFT_STEP);
  assign step_amt = last_o ? cnt_q[SW-1:0] : SW'(SHIFT_STEP);
  assign step_o   = shift_by(op_q, val_q, SAW'(step_amt));
  assign comb_o   = data_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      cnt_q <= '0;
      op_q  <= SH_SLL;
    end else if (load_i) begin
      val_q <= data_i;
      cnt_q <= shamt_i;
      op_q  <= op_i;
    end else if (advance_i && !last_o) begin
      val_q <= step_o;
      cnt_q <= cnt_q - SAW'(step_amt);
    end
  end
`else
  logic unused_serial;

  assign comb_o        = shift_by(op_i, data_i, shamt_i);
  assign step_o        = '0;
  assign last_o        = 1'b1;
  assign unused_serial = ^{clk, rst, load_i, advance_i, SHIFT_STEP != 0};
`endif

endmodule

// File: rtl/alu_imm_exec_unit.sv
// Registered, valid/ready OP-IMM execution unit (ADDI..SRAI) for XLEN 32/64 with flush
// and illegal-shamt detection; define ALU_IMM_SERIAL_SHIFT_EN for the iterative shifter.
module alu_imm_exec_unit
  import alu_imm_exec_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int SHIFT_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  output logic                busy,
  alu_imm_exec_unit_if.slave  bus
);

  localparam int SAW = $clog2(XLEN);

  alu_imm_state_e    state_q;
  logic              wb_vld_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic              wb_illegal_q;

  logic [XLEN-1:0]   imm_sext;
  logic [SAW-1:0]    shamt;
  logic              is_shift;
  logic              illegal_d;
  logic [XLEN-1:0]   result_d;
  logic              go_shift;
  logic              accept;
  logic [XLEN-1:0]   sh_comb;
  logic [XLEN-1:0]   sh_step;
  logic              sh_last;

  assign imm_sext = {{(XLEN-12){bus.in_imm12[11]}}, bus.in_imm12};
  assign shamt    = bus.in_imm12[SAW-1:0];
  assign is_shift = (bus.in_funct3 == ALU_IMM_FUNCT3_SLLI) || (bus.in_funct3 == ALU_IMM_FUNCT3_SRXI);

  // Right shifts tolerate only imm12[10] (the SRAI marker) above the shamt field.
  always_comb begin
    illegal_d = 1'b0;
    if (bus.in_funct3 == ALU_IMM_FUNCT3_SLLI)
      illegal_d = |bus.in_imm12[11:SAW];
    else if (bus.in_funct3 == ALU_IMM_FUNCT3_SRXI)
      illegal_d = bus.in_imm12[11] | (|bus.in_imm12[9:SAW]);
  end

  // NOTE: result_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    result_d = '0;
    case (bus.in_funct3)
      ALU_IMM_FUNCT3_ADDI:  result_d = bus.in_rs1_data + imm_sext;
      ALU_IMM_FUNCT3_SLTI:  result_d = {{(XLEN-1){1'b0}}, $signed(bus.in_rs1_data) < $signed(imm_sext)};
      ALU_IMM_FUNCT3_SLTIU: result_d = {{(XLEN-1){1'b0}}, bus.in_rs1_data < imm_sext};
      ALU_IMM_FUNCT3_XORI:  result_d = bus.in_rs1_data ^ imm_sext;
      ALU_IMM_FUNCT3_ORI:   result_d = bus.in_rs1_data | imm_sext;
      ALU_IMM_FUNCT3_ANDI:  result_d = bus.in_rs1_data & imm_sext;
      default:              result_d = sh_comb;
    endcase
    if (illegal_d) result_d = '0;
  end

`ifdef ALU_IMM_SERIAL_SHIFT_EN
  assign go_shift = is_shift & ~illegal_d & (|shamt);
`else
  assign go_shift = 1'b0;
`endif

  assign bus.in_rdy = ~flush & ((state_q == IDLE) | ((state_q == DONE) & bus.wb_rdy));
  assign accept     = bus.in_vld & bus.in_rdy;

  alu_imm_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .advance_i (state_q == SHIFT),
    .op_i      (shift_op(bus.in_funct3, bus.in_imm12[10])),
    .data_i    (bus.in_rs1_data),
    .shamt_i   (shamt),
    .comb_o    (sh_comb),
    .step_o    (sh_step),
    .last_o    (sh_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wb_vld_q     <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_illegal_q <= 1'b0;
    end else if (flush) begin
      state_q  <= IDLE;
      wb_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            wb_rd_q <= bus.in_rd;
            if (go_shift) begin
              state_q      <= SHIFT;
              wb_vld_q     <= 1'b0;
              wb_illegal_q <= 1'b0;
            end else begin
              state_q      <= DONE;
              wb_vld_q     <= 1'b1;
              wb_data_q    <= result_d;
              wb_illegal_q <= illegal_d;
            end
          end else if ((state_q == DONE) && bus.wb_rdy) begin
            state_q  <= IDLE;
            wb_vld_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (sh_last) begin
            state_q   <= DONE;
            wb_vld_q  <= 1'b1;
            wb_data_q <= sh_step;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wb_vld     = wb_vld_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_illegal = wb_illegal_q;
  assign bus.wb_wen     = (wb_rd_q != '0) & ~wb_illegal_q;
  assign busy           = state_q != IDLE;

endmodule

// File: tb/tb_alu_imm_exec_unit.sv
// Self-checking bench for alu_imm_exec_unit (XLEN=32); expected latency follows
// ALU_IMM_SERIAL_SHIFT_EN when the bench is built with it.
module tb_alu_imm_exec_unit;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int STEP = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  alu_imm_exec_unit_if #(.XLEN(XLEN), .REG_AW(AW)) bus ();

  alu_imm_exec_unit #(.XLEN(XLEN), .REG_AW(AW), .SHIFT_STEP(STEP)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        illegal;
    logic        wen;
    logic [4:0]  rd;
    int          lat;
    int          acc_cyc;
    bit          seen;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic [4:0]  rd;
  } vec_t;

  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one OP-IMM instruction, straight from the ISA rules.
  function automatic exp_t model(input logic [2:0] f3, input logic [11:0] imm,
                                 input logic [31:0] rs1, input logic [4:0] rd);
    exp_t        e;
    logic [31:0] imm_s;
    logic [6:0]  hi;
    int          sh;
    imm_s     = {{20{imm[11]}}, imm};
    hi        = imm[11:5];
    sh        = int'(imm[4:0]);
    e.data    = 32'h0;
    e.illegal = 1'b0;
    e.lat     = 1;
    e.acc_cyc = 0;
    e.seen    = 1'b0;
    e.rd      = rd;
    case (f3)
      3'd0: e.data = rs1 + imm_s;
      3'd2: e.data = ($signed(rs1) < $signed(imm_s)) ? 32'd1 : 32'd0;
      3'd3: e.data = (rs1 < imm_s) ? 32'd1 : 32'd0;
      3'd4: e.data = rs1 ^ imm_s;
      3'd6: e.data = rs1 | imm_s;
      3'd7: e.data = rs1 & imm_s;
      3'd1: if (hi != 7'd0) e.illegal = 1'b1; else e.data = rs1 << sh;
      default: begin
        if (hi == 7'd0)              e.data = rs1 >> sh;
        else if (hi == 7'b0100000)   e.data = (rs1 >> sh) | (rs1[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        else                         e.illegal = 1'b1;
      end
    endcase
    if (e.illegal) e.data = 32'h0;
`ifdef ALU_IMM_SERIAL_SHIFT_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && !e.illegal && sh != 0) e.lat = (sh + STEP - 1) / STEP + 1;
`endif
    e.wen = (rd != 5'd0) && !e.illegal;
    return e;
  endfunction

  // Compare process: every cycle out of reset, check outputs/handshake against the queue.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      logic exp_rdy;
      exp_rdy = !flush && (q.size() == 0 ||
                (cyc - q[0].acc_cyc >= q[0].lat && bus.wb_rdy));
      check("in_rdy", bus.in_rdy, exp_rdy);
      check("busy", busy, q.size() != 0);
      if (bus.wb_vld) begin
        if (q.size() == 0) begin
          check("spurious_wb_vld", 1'b1, 1'b0);
        end else begin
          check("wb_data", bus.wb_data, q[0].data);
          check("wb_rd", bus.wb_rd, q[0].rd);
          check("wb_wen", bus.wb_wen, q[0].wen);
          check("wb_illegal", bus.wb_illegal, q[0].illegal);
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            check("latency", cyc - q[0].acc_cyc, q[0].lat);
          end
          if (bus.wb_rdy && !flush) void'(q.pop_front());
        end
      end else if (q.size() != 0 && !q[0].seen && cyc - q[0].acc_cyc >= q[0].lat) begin
        q[0].seen = 1'b1;
        check("wb_vld_late", 1'b0, 1'b1);
      end
      if (flush) begin
        q.delete();
      end else if (bus.in_vld && bus.in_rdy) begin
        exp_t e;
        e = model(bus.in_funct3, bus.in_imm12, bus.in_rs1_data, bus.in_rd);
        e.acc_cyc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f3, input logic [11:0] imm,
                      input logic [31:0] rs1, input logic [4:0] rd);
    int k;
    bus.in_funct3   = f3;
    bus.in_imm12    = imm;
    bus.in_rs1_data = rs1;
    bus.in_rd       = rd;
    bus.in_vld      = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_rdy) break;
    end
    check("accept_timeout", k < 200, 1'b1);
    tick();
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.wb_vld) break;
    end
    tick();
    check("drain_timeout", q.size(), 0);
  endtask

  vec_t vecs [16] = '{
    '{3'd0, 12'h001, 32'hFFFF_FFFF, 5'd5},
    '{3'd3, 12'hFFF, 32'h0000_0005, 5'd6},
    '{3'd2, 12'hFFF, 32'h0000_0005, 5'd7},
    '{3'd5, 12'h41F, 32'h8000_0000, 5'd8},
    '{3'd1, 12'h020, 32'h0000_1234, 5'd9},
    '{3'd4, 12'h0F0, 32'hA5A5_A5A5, 5'd10},
    '{3'd6, 12'h800, 32'h0000_000F, 5'd11},
    '{3'd7, 12'h7FF, 32'hFFFF_FFFF, 5'd12},
    '{3'd1, 12'h004, 32'h0000_0001, 5'd13},
    '{3'd5, 12'h01F, 32'h8000_0000, 5'd14},
    '{3'd5, 12'h404, 32'hF000_0000, 5'd15},
    '{3'd5, 12'h000, 32'hDEAD_BEEF, 5'd16},
    '{3'd5, 12'h605, 32'hFFFF_FFFF, 5'd17},
    '{3'd5, 12'hC03, 32'h0000_0040, 5'd18},
    '{3'd2, 12'h800, 32'h8000_0000, 5'd1},
    '{3'd0, 12'h7FF, 32'h7FFF_FFFF, 5'd0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst             = 1'b1;
    flush           = 1'b0;
    bus.in_vld      = 1'b0;
    bus.in_funct3   = 3'd0;
    bus.in_imm12    = 12'd0;
    bus.in_rs1_data = 32'd0;
    bus.in_rd       = 5'd0;
    bus.wb_rdy      = 1'b0;

    tick();
    tick();
    check("rst_wb_vld", bus.wb_vld, 1'b0);
    check("rst_wb_data", bus.wb_data, 32'h0);
    check("rst_wb_rd", bus.wb_rd, 5'd0);
    check("rst_wb_wen", bus.wb_wen, 1'b0);
    check("rst_wb_illegal", bus.wb_illegal, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_rdy", bus.in_rdy, 1'b1);
    tick();

    // Hand-computed pins of the model itself.
    e = model(3'd0, 12'h001, 32'hFFFF_FFFF, 5'd5);
    check("pin_addi_data", e.data, 32'h0);
    check("pin_addi_wen", e.wen, 1'b1);
    e = model(3'd3, 12'hFFF, 32'd5, 5'd1);
    check("pin_sltiu", e.data, 32'd1);
    e = model(3'd2, 12'hFFF, 32'd5, 5'd1);
    check("pin_slti", e.data, 32'd0);
    e = model(3'd5, 12'h41F, 32'h8000_0000, 5'd1);
    check("pin_srai", e.data, 32'hFFFF_FFFF);
`ifdef ALU_IMM_SERIAL_SHIFT_EN
    check("pin_srai_lat", e.lat, 9);
`else
    check("pin_srai_lat", e.lat, 1);
`endif
    e = model(3'd1, 12'h020, 32'd1, 5'd1);
    check("pin_slli_illegal", e.illegal, 1'b1);
    check("pin_slli_wen", e.wen, 1'b0);
    e = model(3'd0, 12'h7FF, 32'd1, 5'd0);
    check("pin_rd0_wen", e.wen, 1'b0);

    // First vector with literal expectations on the very next cycle.
    bus.wb_rdy = 1'b1;
    send(vecs[0].f3, vecs[0].imm, vecs[0].rs1, vecs[0].rd);
    @(negedge clk);
    check("addi_lit_vld", bus.wb_vld, 1'b1);
    check("addi_lit_data", bus.wb_data, 32'h0);
    check("addi_lit_wen", bus.wb_wen, 1'b1);
    check("addi_lit_rd", bus.wb_rd, 5'd5);
    tick();

    for (int i = 1; i < 16; i++) send(vecs[i].f3, vecs[i].imm, vecs[i].rs1, vecs[i].rd);
    wait_empty();

    // Back-pressure: result held 3 cycles, next op accepted on the drain cycle.
    bus.wb_rdy = 1'b0;
    send(3'd6, 12'h00F, 32'h0000_00F0, 5'd3);
    bus.in_funct3   = 3'd4;
    bus.in_imm12    = 12'hFFF;
    bus.in_rs1_data = 32'h1234_5678;
    bus.in_rd       = 5'd4;
    bus.in_vld      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold_data", bus.wb_data, 32'h0000_00FF);
    end
    tick();
    bus.wb_rdy = 1'b1;
    send(3'd4, 12'hFFF, 32'h1234_5678, 5'd4);
    wait_empty();

    // Flush a long right shift while it is in flight.
    bus.wb_rdy = 1'b0;
    send(3'd5, 12'h01F, 32'h8000_0000, 5'd9);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_rdy_low", bus.in_rdy, 1'b0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_no_wb_vld", bus.wb_vld, 1'b0);
    check("flush_in_rdy", bus.in_rdy, 1'b1);
    check("flush_busy", busy, 1'b0);
    tick();

    // Flush with in_vld in the same cycle must not accept.
    flush           = 1'b1;
    bus.in_funct3   = 3'd0;
    bus.in_imm12    = 12'h005;
    bus.in_rs1_data = 32'd1;
    bus.in_rd       = 5'd2;
    bus.in_vld      = 1'b1;
    @(negedge clk);
    check("flush_vld_rdy", bus.in_rdy, 1'b0);
    tick();
    flush      = 1'b0;
    bus.in_vld = 1'b0;
    @(negedge clk);
    check("flush_vld_no_wb", bus.wb_vld, 1'b0);
    tick();

    // Asynchronous reset while a result is pending.
    send(3'd0, 12'h003, 32'd4, 5'd2);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_wb_vld", bus.wb_vld, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_wb_data", bus.wb_data, 32'h0);
    tick();
    rst        = 1'b0;
    bus.wb_rdy = 1'b1;
    @(negedge clk);
    check("midrst_in_rdy", bus.in_rdy, 1'b1);
    check("midrst_no_wb", bus.wb_vld, 1'b0);
    tick();

    send(3'd1, 12'h01F, 32'h0000_0001, 5'd31);
    wait_empty();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
